// File: rtl/vga_fetch_sched.sv
// Frame-rate burst read scheduler: SDRAM framebuffer (Avalon-MM) -> VGA pixel FIFO.
// Latency: mem_read rises one cycle after frame_start; requests are held by FIFO credit and by mem_waitrequest.
module vga_fetch_sched #(
    parameter int              HDISP      = 800,
    parameter int              VDISP      = 480,
    parameter int              BURST      = 16,
    parameter int              FIFO_DEPTH = 256,
    parameter int              AW         = 32,
    parameter logic [AW-1:0]   BASE_ADDR  = '0
) (
    input  logic                            pixel_clk,
    input  logic                            pixel_rst_n,
    input  logic                            enable,
    input  logic                            frame_start,
    input  logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [AW-1:0]                   mem_address,
    output logic                            mem_read,
    output logic [$clog2(BURST):0]          mem_burstcount,
    input  logic                            mem_waitrequest,
    input  logic                            mem_readdatavalid,
    output logic                            fifo_flush,
    output logic                            busy,
    output logic                            overrun
);

    localparam int LW      = $clog2(FIFO_DEPTH) + 1;
    localparam int CW      = LW + 2;
    localparam int NBURSTS = HDISP * VDISP / BURST;
    localparam int BCW     = $clog2(NBURSTS) + 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_FRAME, FETCH, RESYNC, DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic           mem_read_q, mem_read_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [LW-1:0]  outstanding_q, outstanding_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic           overrun_q, overrun_d;
    logic           flush_q, flush_d;
    logic           busy_q, busy_d;

    logic           accept;
    logic           last_burst;
    logic           credit_ok;
    logic [CW-1:0]  credit_sum;

    assign accept     = mem_read_q && !mem_waitrequest;
    assign last_burst = (burst_cnt_q == BCW'(NBURSTS - 1));
    // Widened sum so a large fifo_level plus outstanding can never wrap past the limit.
    assign credit_sum = CW'(fifo_level) + CW'(outstanding_q) + CW'(BURST);
    assign credit_ok  = (credit_sum <= CW'(FIFO_DEPTH));

    always_comb begin
        state_d       = state_q;
        mem_read_d    = mem_read_q;
        addr_d        = addr_q;
        burst_cnt_d   = burst_cnt_q;
        overrun_d     = overrun_q;
        flush_d       = 1'b0;
        outstanding_d = outstanding_q;

        if (accept) begin
            outstanding_d = outstanding_d + LW'(BURST);
            mem_read_d    = 1'b0;
        end
        // Stray data with nothing outstanding (e.g. left over from before a reset) is ignored.
        if (mem_readdatavalid && (outstanding_q != '0 || accept))
            outstanding_d = outstanding_d - LW'(1);

        case (state_q)
            IDLE: begin
                if (enable)
                    state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!enable) begin
                    state_d = DRAIN;
                end else if (frame_start) begin
                    state_d    = FETCH;
                    mem_read_d = credit_ok;
                end
            end
            FETCH: begin
                if (accept) begin
                    if (last_burst) begin
                        addr_d      = BASE_ADDR;
                        burst_cnt_d = '0;
                        state_d     = WAIT_FRAME;
                    end else begin
                        addr_d      = addr_q + AW'(BURST * 4);
                        burst_cnt_d = burst_cnt_q + BCW'(1);
                    end
                end
                // A stalled request keeps mem_read high; only new issues are suppressed.
                if (!enable) begin
                    state_d = DRAIN;
                end else if (frame_start) begin
                    overrun_d = 1'b1;
                    state_d   = RESYNC;
                end else if (!mem_read_q && credit_ok) begin
                    mem_read_d = 1'b1;
                end
            end
            RESYNC: begin
                if (!enable) begin
                    state_d = DRAIN;
                end else if (!mem_read_q && outstanding_q == '0) begin
                    flush_d     = 1'b1;
                    addr_d      = BASE_ADDR;
                    burst_cnt_d = '0;
                    state_d     = FETCH;
                end
            end
            DRAIN: begin
                if (!mem_read_q && outstanding_q == '0) begin
                    addr_d      = BASE_ADDR;
                    burst_cnt_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == FETCH) || (state_d == RESYNC) || (state_d == DRAIN);
    end

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            addr_q        <= BASE_ADDR;
            outstanding_q <= '0;
            burst_cnt_q   <= '0;
            overrun_q     <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            addr_q        <= addr_d;
            outstanding_q <= outstanding_d;
            burst_cnt_q   <= burst_cnt_d;
            overrun_q     <= overrun_d;
            flush_q       <= flush_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_address    = addr_q;
    assign mem_read       = mem_read_q;
    assign mem_burstcount = ($clog2(BURST) + 1)'(BURST);
    assign fifo_flush     = flush_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;

endmodule
